// File: rtl/pc_stack_unit.sv
// pc_stack_unit
// -----------------------------------------------------------------------------
// Program counter with an integrated return-address stack (RAS) and an
// interrupt vector load. It sits in the fetch path and drives the
// instruction-memory address. CALL, RET and interrupt entry each complete in
// one cycle without any data-memory stack traffic.
//
// One action per cycle, by priority:
//   RST > (STALL) > INTR > RET > CALL > PC_LD > PC_INC > hold
// Lower-priority requests in the same cycle are dropped, not queued.
// Requests are plain level strobes sampled on each rising CLK edge. There is
// no valid/ready handshake: the unit always accepts the winning request.
//
// Optional build macro:
//   PC_STACK_STALL_EN : adds input STALL. When STALL=1 (and RST=0) all state
//                       holds and every request in that cycle is discarded.
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   synchronous active-high reset
//   STALL      in   freeze (only with PC_STACK_STALL_EN)
//   DIN        in   branch / call target
//   PC_LD      in   load DIN
//   PC_INC     in   increment PC
//   CALL       in   push PC_COUNT+1, load DIN
//   RET        in   pop top of stack into PC
//   INTR       in   push PC_COUNT, load INTR_VEC
//   PC_COUNT   out  current PC
//   SP_DEPTH   out  number of valid stack entries
//   STK_FULL   out  SP_DEPTH == STACK_DEPTH
//   STK_EMPTY  out  SP_DEPTH == 0
//   STK_ERR    out  sticky overflow/underflow flag, cleared only by RST
// -----------------------------------------------------------------------------
module pc_stack_unit #(
  parameter int                ADDR_W      = 10,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter logic [ADDR_W-1:0] INTR_VEC    = '1,
  localparam int               SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef PC_STACK_STALL_EN
  input  logic              STALL,
`endif
  input  logic [ADDR_W-1:0] DIN,
  input  logic              PC_LD,
  input  logic              PC_INC,
  input  logic              CALL,
  input  logic              RET,
  input  logic              INTR,
  output logic [ADDR_W-1:0] PC_COUNT,
  output logic [SP_W-1:0]   SP_DEPTH,
  output logic              STK_FULL,
  output logic              STK_EMPTY,
  output logic              STK_ERR
);

  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_nxt, pc_plus1;
  logic [SP_W-1:0]   sp_q, sp_nxt, sp_dec;
  logic              err_q, err_nxt;
  logic              full, empty, stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_data;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

`ifdef PC_STACK_STALL_EN
  assign stall = STALL;
`else
  assign stall = 1'b0;
`endif

  assign full     = (sp_q == SP_W'(STACK_DEPTH));
  assign empty    = (sp_q == '0);
  assign pc_plus1 = pc_q + ADDR_W'(1);  // wraps all-ones to zero silently
  assign sp_dec   = sp_q - SP_W'(1);

  // Pushes only happen when not full, so sp_q < STACK_DEPTH fits IDX_W bits;
  // pops only happen when not empty, so sp_q-1 fits as well.
  assign wr_idx = sp_q[IDX_W-1:0];
  assign rd_idx = sp_dec[IDX_W-1:0];

  always_comb begin
    pc_nxt  = pc_q;
    sp_nxt  = sp_q;
    err_nxt = err_q;
    wr_en   = 1'b0;
    wr_data = '0;
    if (!stall) begin
      if (INTR) begin
        pc_nxt = INTR_VEC;
        if (full) begin
          err_nxt = 1'b1;          // overflow: push dropped, vector still taken
        end else begin
          wr_en   = 1'b1;
          wr_data = pc_q;          // resume at the interrupted instruction
          sp_nxt  = sp_q + SP_W'(1);
        end
      end else if (RET) begin
        if (empty) begin
          err_nxt = 1'b1;          // underflow: PC holds
        end else begin
          pc_nxt = stack_mem[rd_idx];
          sp_nxt = sp_dec;
        end
      end else if (CALL) begin
        pc_nxt = DIN;
        if (full) begin
          err_nxt = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_data = pc_plus1;      // return to the instruction after the call
          sp_nxt  = sp_q + SP_W'(1);
        end
      end else if (PC_LD) begin
        pc_nxt = DIN;
      end else if (PC_INC) begin
        pc_nxt = pc_plus1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      sp_q  <= sp_nxt;
      err_q <= err_nxt;
    end
  end

  // Stack storage has no reset; synchronous write, asynchronous read.
  always_ff @(posedge CLK) begin
    if (wr_en && !RST) begin
      stack_mem[wr_idx] <= wr_data;
    end
  end

  assign PC_COUNT  = pc_q;
  assign SP_DEPTH  = sp_q;
  assign STK_FULL  = full;
  assign STK_EMPTY = empty;
  assign STK_ERR   = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit
// Directed bench for pc_stack_unit at default parameters (ADDR_W=10,
// STACK_DEPTH=8, RESET_VEC=0, INTR_VEC=0x3FF). Return addresses pushed by the
// bench are held in exp_q and popped in LIFO order to check RET results.
module tb_pc_stack_unit;

  localparam int AW = 10;
  localparam int SW = 4;

  logic          clk;
  logic          rst;
  logic          stall;
  logic [AW-1:0] din;
  logic          pc_ld, pc_inc, call, ret, intr;
  logic [AW-1:0] pc_count;
  logic [SW-1:0] sp_depth;
  logic          stk_full, stk_empty, stk_err;

  int errors;
  int checks;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_pc;
  logic [AW-1:0] exp_ret;

  pc_stack_unit dut (
    .CLK       (clk),
    .RST       (rst),
`ifdef PC_STACK_STALL_EN
    .STALL     (stall),
`endif
    .DIN       (din),
    .PC_LD     (pc_ld),
    .PC_INC    (pc_inc),
    .CALL      (call),
    .RET       (ret),
    .INTR      (intr),
    .PC_COUNT  (pc_count),
    .SP_DEPTH  (sp_depth),
    .STK_FULL  (stk_full),
    .STK_EMPTY (stk_empty),
    .STK_ERR   (stk_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // driver: apply one cycle of requests, then release them #1 after the edge
  task automatic step(input logic [AW-1:0] d, input logic ld, input logic inc,
                      input logic cl, input logic rt, input logic it,
                      input logic rs);
    din    = d;
    pc_ld  = ld;
    pc_inc = inc;
    call   = cl;
    ret    = rt;
    intr   = it;
    rst    = rs;
    @(posedge clk);
    #1;
    din    = '0;
    pc_ld  = 1'b0;
    pc_inc = 1'b0;
    call   = 1'b0;
    ret    = 1'b0;
    intr   = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic do_reset();
    step('0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    stall  = 1'b0;
    din    = '0;
    pc_ld  = 1'b0;
    pc_inc = 1'b0;
    call   = 1'b0;
    ret    = 1'b0;
    intr   = 1'b0;
    @(negedge clk);

    // reset / increment
    do_reset();
    check_val("rst_pc", pc_count, 0);
    check_val("rst_sp", sp_depth, 0);
    check_val("rst_empty", stk_empty, 1);
    check_val("rst_full", stk_full, 0);
    check_val("rst_err", stk_err, 0);
    for (int i = 1; i <= 3; i++) begin
      step('0, 0, 1, 0, 0, 0, 0);
      check_val("inc_pc", pc_count, i);
    end
    check_val("inc_empty", stk_empty, 1);
    step('0, 0, 0, 0, 0, 0, 0);
    check_val("hold_pc", pc_count, 3);

    // call / return
    step(10'h005, 1, 0, 0, 0, 0, 0);
    check_val("ld_pc", pc_count, 10'h005);
    step(10'h120, 0, 0, 1, 0, 0, 0);
    check_val("call_pc", pc_count, 10'h120);
    check_val("call_sp", sp_depth, 1);
    check_val("call_empty", stk_empty, 0);
    step('0, 0, 1, 0, 0, 0, 0);
    step('0, 0, 1, 0, 0, 0, 0);
    check_val("call_inc_pc", pc_count, 10'h122);
    step('0, 0, 0, 0, 1, 0, 0);
    check_val("ret_pc", pc_count, 10'h006);
    check_val("ret_sp", sp_depth, 0);

    // interrupt wins over CALL and PC_INC; only one push
    step(10'h040, 1, 0, 0, 0, 0, 0);
    step(10'h077, 0, 1, 1, 0, 1, 0);
    check_val("intr_pc", pc_count, 10'h3FF);
    check_val("intr_sp", sp_depth, 1);
    step('0, 0, 0, 0, 1, 0, 0);
    check_val("intr_ret_pc", pc_count, 10'h040);
    check_val("intr_ret_sp", sp_depth, 0);
    check_val("intr_err", stk_err, 0);

    // overflow: 9 CALLs with DIN=k, starting from PC=0x040
    exp_pc = 10'h040;
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) exp_q.push_back(exp_pc + 10'd1);
      step(AW'(k), 0, 0, 1, 0, 0, 0);
      exp_pc = AW'(k);
    end
    check_val("ovf_pc", pc_count, 9);
    check_val("ovf_sp", sp_depth, 8);
    check_val("ovf_full", stk_full, 1);
    check_val("ovf_err", stk_err, 1);
    // expected LIFO order: 8,7,6,5,4,3,2,0x041
    for (int k = 0; k < 8; k++) begin
      step('0, 0, 0, 0, 1, 0, 0);
      exp_ret = exp_q.pop_back();
      check_val("ovf_ret_pc", pc_count, exp_ret);
      check_val("ovf_ret_sp", sp_depth, 7 - k);
    end
    check_val("ovf_drain_empty", stk_empty, 1);
    check_val("ovf_err_sticky", stk_err, 1);

    // underflow / reset
    do_reset();
    step(10'h010, 1, 0, 0, 0, 0, 0);
    step('0, 0, 0, 0, 1, 0, 0);
    check_val("unf_pc", pc_count, 10'h010);
    check_val("unf_sp", sp_depth, 0);
    check_val("unf_err", stk_err, 1);
    step(10'h055, 0, 0, 1, 0, 0, 1);
    check_val("rst_call_pc", pc_count, 0);
    check_val("rst_call_sp", sp_depth, 0);
    check_val("rst_call_err", stk_err, 0);

    // priority: PC_LD over PC_INC; RET over CALL
    step(10'h200, 1, 1, 0, 0, 0, 0);
    check_val("ld_over_inc", pc_count, 10'h200);
    step(10'h300, 0, 0, 1, 0, 0, 0);
    step(10'h1AB, 0, 0, 1, 1, 0, 0);
    check_val("ret_over_call_pc", pc_count, 10'h201);
    check_val("ret_over_call_sp", sp_depth, 0);

    // wrap
    step(10'h3FF, 1, 0, 0, 0, 0, 0);
    step('0, 0, 1, 0, 0, 0, 0);
    check_val("inc_wrap", pc_count, 0);
    check_val("inc_wrap_err", stk_err, 0);
    step(10'h3FF, 1, 0, 0, 0, 0, 0);
    step(10'h123, 0, 0, 1, 0, 0, 0);
    check_val("wrap_call_pc", pc_count, 10'h123);
    step('0, 0, 0, 0, 1, 0, 0);
    check_val("wrap_ret_pc", pc_count, 10'h000);

`ifdef PC_STACK_STALL_EN
    step(10'h050, 1, 0, 0, 0, 0, 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step('0, 0, 1, 0, 0, 0, 0);
      check_val("stall_pc", pc_count, 10'h050);
    end
    step(10'h0AA, 0, 0, 1, 0, 0, 0);
    check_val("stall_call_sp", sp_depth, 0);
    step('0, 0, 0, 0, 0, 0, 1);
    check_val("stall_rst_pc", pc_count, 0);
    stall = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
